// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: runs MEM-stage data-memory accesses on a variable-latency
// req/ack bus. The pipeline is stalled until the access finishes. Load data is
// returned on mem_rdata. Misaligned or timed-out accesses raise bus_err.
module dmem_access_ctrl #(
  parameter int          TIMEOUT_CYC = 16,
  parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_dmen,
  input  logic        mem_memwr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        pa_idexmemwr,
  output logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Value of the wait counter in the last BUSY cycle before the access is aborted.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic        bus_err_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] mem_rdata_q;

  // Hold the pipeline while an access is in flight, or while a new request is
  // waiting in IDLE. DONE releases the stall so the pipeline registers advance.
  assign pa_idexmemwr = (state_q == BUSY) || ((state_q == IDLE) && mem_dmen);

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_err   = bus_err_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign mem_rdata = mem_rdata_q;

  // Access sequencer. This one block holds the state, the bus outputs, the
  // wait counter and the load data.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      mem_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_dmen) begin
            if (mem_addr[1:0] == 2'b00) begin
              // Start the bus transfer. The address and data held here stay
              // stable for as long as bus_req is high.
              state_q     <= BUSY;
              bus_req_q   <= 1'b1;
              bus_we_q    <= mem_memwr;
              bus_addr_q  <= mem_addr;
              bus_wdata_q <= mem_wdata;
              cnt_q       <= '0;
            end else begin
              // Misaligned: skip the bus and report the error straight away.
              state_q   <= DONE;
              bus_err_q <= 1'b1;
              if (!mem_memwr) begin
                mem_rdata_q <= ERR_RDATA;
              end
            end
          end
        end

        BUSY: begin
          if (bus_ack) begin
            // An ack always wins, including one that arrives in the last allowed cycle.
            state_q   <= DONE;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            if (!bus_we_q) begin
              mem_rdata_q <= bus_rdata;
            end
          end else if (cnt_q == LAST_CNT) begin
            state_q   <= DONE;
            bus_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            if (!bus_we_q) begin
              mem_rdata_q <= ERR_RDATA;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        DONE: begin
          // One cycle with no stall. Clearing the error here makes it a single-cycle pulse.
          state_q   <= IDLE;
          bus_err_q <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed and random accesses against a per-access
// reference model. Each access is described only by its expected totals:
// stall cycles, request cycles, error and returned load data.
module tb_dmem_access_ctrl;

  localparam int          T   = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_dmen;
  logic        mem_memwr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        pa_idexmemwr;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  dmem_access_ctrl #(
    .TIMEOUT_CYC(T),
    .ERR_RDATA  (ERR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_dmen    (mem_dmen),
    .mem_memwr   (mem_memwr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .pa_idexmemwr(pa_idexmemwr),
    .mem_rdata   (mem_rdata),
    .bus_err     (bus_err),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_rdata;
  int          last_ack_cyc;
  int          first_req_cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Runs one access. ack_at is the bus_req cycle (1-based) in which the bench
  // acks; 0 or anything above T means the bench never acks. rd is the data
  // returned with the ack.
  task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input int ack_at, input logic [31:0] rd);
    bit   aligned, acked, done;
    int   exp_req, exp_stall, stall_n, req_n;
    logic exp_err;
    aligned   = (addr[1:0] == 2'b00);
    acked     = aligned && (ack_at >= 1) && (ack_at <= T);
    exp_req   = !aligned ? 0 : (acked ? ack_at : T);
    exp_stall = aligned ? exp_req + 1 : 1;
    exp_err   = !acked;
    if (!we) exp_rdata = acked ? rd : ERR;

    @(negedge clk);
    mem_dmen  = 1'b1;
    mem_memwr = we;
    mem_addr  = addr;
    mem_wdata = wdata;
    stall_n   = 0;
    req_n     = 0;
    done      = 0;
    for (int g = 0; g < T + 4 && !done; g++) begin
      if (g != 0) @(negedge clk);
      #1;
      if (pa_idexmemwr) begin
        stall_n++;
        check("err_during_stall", 32'(bus_err), 32'd0);
        if (bus_req) begin
          req_n++;
          if (req_n == 1) first_req_cyc = cyc;
          check("bus_addr", bus_addr, addr);
          check("bus_we", 32'(bus_we), 32'(we));
          check("bus_wdata", bus_wdata, wdata);
          bus_ack   = (req_n == ack_at);
          bus_rdata = bus_ack ? rd : $urandom;
          if (bus_ack) last_ack_cyc = cyc;
        end else begin
          // No request is outstanding, so the controller must ignore this ack.
          bus_ack   = 1'($urandom_range(0, 1));
          bus_rdata = $urandom;
        end
      end else begin
        done = 1;
        check("done_req_low", 32'(bus_req), 32'd0);
        check("done_err", 32'(bus_err), 32'(exp_err));
        check("done_rdata", mem_rdata, exp_rdata);
        check("stall_cycles", 32'(stall_n), 32'(exp_stall));
        check("req_cycles", 32'(req_n), 32'(exp_req));
        mem_dmen  = 1'b0;
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
    end
    if (!done) check("access_never_finished", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, 32'(pa_idexmemwr), 32'd0);
    check({tag, "_req"}, 32'(bus_req), 32'd0);
    check({tag, "_we"}, 32'(bus_we), 32'd0);
    check({tag, "_err"}, 32'(bus_err), 32'd0);
    check({tag, "_addr"}, bus_addr, 32'd0);
    check({tag, "_wdata"}, bus_wdata, 32'd0);
    check({tag, "_rdata"}, mem_rdata, 32'd0);
  endtask

  initial begin
    int a;
    reset     = 1'b1;
    mem_dmen  = 1'b0;
    mem_memwr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    exp_rdata = '0;
    last_ack_cyc  = 0;
    first_req_cyc = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_outputs("reset");

    // Aligned load, acked in the first BUSY cycle.
    run_access(1'b0, 32'h0000_0100, 32'h0, 1, 32'hCAFE_BABE);
    // Store, acked in the third BUSY cycle. mem_rdata keeps the load data.
    run_access(1'b1, 32'h0000_0204, 32'h1234_5678, 3, 32'h5555_5555);
    // Misaligned load.
    run_access(1'b0, 32'h0000_0101, 32'h0, 1, 32'h0);
    // Misaligned store: mem_rdata keeps ERR.
    run_access(1'b1, 32'h0000_0102, 32'hAAAA_0000, 1, 32'h0);
    // Timeout on a load that is never acked.
    run_access(1'b0, 32'h0000_0400, 32'h0, 0, 32'h0);
    // Load acked in the final allowed BUSY cycle completes normally.
    run_access(1'b0, 32'h0000_0404, 32'h0, T, 32'h0BAD_F00D);
    // Back-to-back accesses. The sample points are: ack cycle, DONE, IDLE,
    // then the next request. So the next request is seen 3 samples after the ack.
    run_access(1'b0, 32'h0000_0010, 32'h0, 1, 32'h1111_2222);
    a = last_ack_cyc;
    run_access(1'b1, 32'h0000_0014, 32'h3333_4444, 2, 32'h0);
    check("b2b_ack_to_req", 32'(first_req_cyc - a), 32'd3);

    // Assert reset in the middle of a BUSY access, then send a late ack.
    @(negedge clk);
    mem_dmen  = 1'b1;
    mem_memwr = 1'b0;
    mem_addr  = 32'h0000_0300;
    bus_ack   = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid_busy_req", 32'(bus_req), 32'd1);
    reset    = 1'b1;
    mem_dmen = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    check_reset_outputs("rst_mid");
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    check_reset_outputs("late_ack");
    bus_ack   = 1'b0;
    exp_rdata = '0;

    // Random accesses.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] ad;
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad[1:0] = 2'b00;
      run_access(1'($urandom_range(0, 1)), ad, $urandom, $urandom_range(0, T + 1), $urandom);
    end

    bus_ack = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
